// File: rtl/rx_frame_ctrl_if.sv
// Valid/ready output channel of the frame controller.
// The master drives the head frame and the slave returns ready.
interface rx_frame_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [7:0]  out_op;
  logic [31:0] out_payload;

  modport master (
    output out_valid,
    output out_kind,
    output out_op,
    output out_payload,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_kind,
    input  out_op,
    input  out_payload,
    output out_ready
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Frame controller: detects completed serial frames, drops NOPs, and queues the
// rest in a small FIFO read out over a valid/ready channel. Overruns and NOPs are counted.
module rx_frame_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [39:0]                rx_data,
  input  logic                       rx_flag,
  input  logic                       clear_stats,
  rx_frame_ctrl_if.master            out_if,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           overrun_cnt,
  output logic [CNT_W-1:0]           nop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic             flag_q, flag_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [39:0]      mem_q [DEPTH];
  logic [39:0]      mem_d [DEPTH];
  logic [CNT_W-1:0] ovr_q, ovr_d;
  logic [CNT_W-1:0] nop_q, nop_d;

  logic        frame_ev, is_nop, full, valid, pop, push, ovr_inc, nop_inc;
  logic [39:0] head;

  always_comb begin
    frame_ev = rx_flag & ~flag_q;
    is_nop   = (rx_data[39:32] == 8'h00);
    full     = (level_q == LvlW'(DEPTH));
    valid    = (level_q != '0);
    pop      = valid & out_if.out_ready;
    // A full FIFO still accepts the frame when the head leaves in the same cycle.
    push     = frame_ev & ~is_nop & (~full | pop);
    ovr_inc  = frame_ev & ~is_nop & full & ~pop;
    nop_inc  = frame_ev & is_nop;
  end

  always_comb begin
    flag_d   = rx_flag;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Saturating counters; clear takes priority over a same-cycle increment.
  always_comb begin
    ovr_d = ovr_q;
    nop_d = nop_q;
    if (clear_stats) begin
      ovr_d = '0;
      nop_d = '0;
    end else begin
      if (ovr_inc && (ovr_q != '1)) ovr_d = ovr_q + CNT_W'(1);
      if (nop_inc && (nop_q != '1)) nop_d = nop_q + CNT_W'(1);
    end
  end

  // flag_q resets high so a pulse straddling reset release produces no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= '0;
      nop_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      flag_q   <= flag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
      nop_q    <= nop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    head               = mem_q[rd_ptr_q];
    out_if.out_valid   = valid;
    out_if.out_kind    = head[39];
    out_if.out_op      = head[39:32];
    out_if.out_payload = head[31:0];
    fifo_level         = level_q;
    overrun_cnt        = ovr_q;
    nop_cnt            = nop_q;
  end

endmodule
